// File: rtl/uart_rx_fifo.sv
// Receive holding FIFO for a UART: show-ahead head word, sticky overrun/error flags,
// and an optional receive-timeout counter enabled by defining UART_RX_TIMEOUT_EN.
module uart_rx_fifo #(
    parameter int pAddrWidth = 4,
    parameter int pRTO       = 640
) (
    input  logic                  Clk,
    input  logic                  Rst_N,
    input  logic                  Clr,
    input  logic                  CE_16x,
    input  logic [8:0]            RD,
    input  logic                  WE_RHR,
    input  logic                  RE_RHR,
    input  logic                  Clr_Sts,
    output logic [8:0]            RHR,
    output logic                  RxRdy,
    output logic                  RxFull,
    output logic [pAddrWidth:0]   RxCnt,
    output logic                  RxOvr,
    output logic                  RxErr,
    output logic                  RxTO
);

    localparam int cDepth = 1 << pAddrWidth;

    logic [8:0]            mem [cDepth];
    logic [pAddrWidth-1:0] wrPtr, rdPtr;
    logic [pAddrWidth:0]   cnt;
    logic                  empty, full, doWr, doRd, ovrSet;

    // WE_RHR and RE_RHR are single-cycle strobes with no back-pressure: a write is
    // accepted unless the FIFO is full with no pop in the same cycle (then it is
    // dropped and flagged as overrun); a pop on an empty FIFO is ignored.
    assign empty  = (cnt == '0);
    assign full   = (cnt == (pAddrWidth+1)'(cDepth));
    assign doRd   = RE_RHR & ~empty;
    assign doWr   = WE_RHR & (~full | RE_RHR);
    assign ovrSet = WE_RHR & full & ~RE_RHR;

    assign RHR    = empty ? 9'h000 : mem[rdPtr];
    assign RxRdy  = ~empty;
    assign RxFull = full;
    assign RxCnt  = cnt;

    // Storage is deliberately left unreset; the count alone decides what is valid.
    always_ff @(posedge Clk) begin
        if (doWr && !Clr)
            mem[wrPtr] <= RD;
    end

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cnt   <= '0;
            RxOvr <= 1'b0;
            RxErr <= 1'b0;
        end else if (Clr) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cnt   <= '0;
            RxOvr <= 1'b0;
            RxErr <= 1'b0;
        end else begin
            if (doWr) wrPtr <= wrPtr + 1'b1;
            if (doRd) rdPtr <= rdPtr + 1'b1;
            case ({doWr, doRd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            // Setting a sticky flag wins over clearing it in the same cycle.
            if (ovrSet)               RxOvr <= 1'b1;
            else if (Clr_Sts)         RxOvr <= 1'b0;
            if (doWr && RD[8])        RxErr <= 1'b1;
            else if (Clr_Sts)         RxErr <= 1'b0;
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    localparam int cTW = $clog2(pRTO + 1);
    logic [cTW-1:0] tmr;

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            tmr  <= '0;
            RxTO <= 1'b0;
        end else if (Clr || doWr || RE_RHR || empty) begin
            tmr  <= '0;
            RxTO <= 1'b0;
        end else if (CE_16x && tmr != cTW'(pRTO)) begin
            tmr <= tmr + cTW'(1);
            if (tmr == cTW'(pRTO - 1))
                RxTO <= 1'b1;
        end
    end
`else
    logic unusedCe;
    assign unusedCe = CE_16x;
    assign RxTO     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: vector table for single-cycle behaviour plus
// hand sequences for fill/overrun, full-wrap, clear, async reset and timeout.
module tb_uart_rx_fifo;

    localparam int AW = 4;

    logic        Clk = 1'b0;
    logic        Rst_N = 1'b0;
    logic        Clr = 1'b0;
    logic        CE_16x = 1'b0;
    logic [8:0]  RD = '0;
    logic        WE_RHR = 1'b0;
    logic        RE_RHR = 1'b0;
    logic        Clr_Sts = 1'b0;
    logic [8:0]  RHR;
    logic        RxRdy, RxFull, RxOvr, RxErr, RxTO;
    logic [AW:0] RxCnt;

    int total = 0;
    int bad   = 0;
    logic [8:0] exp_q[$];

    uart_rx_fifo #(.pAddrWidth(AW), .pRTO(640)) dut (
        .Clk(Clk), .Rst_N(Rst_N), .Clr(Clr), .CE_16x(CE_16x), .RD(RD),
        .WE_RHR(WE_RHR), .RE_RHR(RE_RHR), .Clr_Sts(Clr_Sts), .RHR(RHR),
        .RxRdy(RxRdy), .RxFull(RxFull), .RxCnt(RxCnt), .RxOvr(RxOvr),
        .RxErr(RxErr), .RxTO(RxTO)
    );

    // clock / reset
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // driver: inputs set on a falling edge, held across one rising edge
    task automatic step(input logic we, input logic re, input logic [8:0] d,
                        input logic clr, input logic clrSts);
        WE_RHR = we; RE_RHR = re; RD = d; Clr = clr; Clr_Sts = clrSts;
        @(negedge Clk);
        WE_RHR = 1'b0; RE_RHR = 1'b0; Clr = 1'b0; Clr_Sts = 1'b0; RD = '0;
    endtask

    task automatic chk_state(input string name, input logic [8:0] rhr, input logic rdy,
                             input logic [AW:0] cnt, input logic full, input logic ovr,
                             input logic err);
        chk({name, ".rhr"},  32'(RHR),    32'(rhr));
        chk({name, ".rdy"},  32'(RxRdy),  32'(rdy));
        chk({name, ".cnt"},  32'(RxCnt),  32'(cnt));
        chk({name, ".full"}, 32'(RxFull), 32'(full));
        chk({name, ".ovr"},  32'(RxOvr),  32'(ovr));
        chk({name, ".err"},  32'(RxErr),  32'(err));
    endtask

    typedef struct {
        logic       we, re, clr, clrSts;
        logic [8:0] d;
        logic [8:0] eRhr;
        logic       eRdy;
        logic [AW:0] eCnt;
        logic       eErr;
    } vec_t;

    vec_t vecs[12];

    initial begin
        // vector table: {we, re, clr, clrSts, data, RHR, RxRdy, RxCnt, RxErr}
        vecs[0]  = '{0, 0, 0, 0, 9'h000, 9'h000, 0, 0, 0};  // idle after reset
        vecs[1]  = '{1, 0, 0, 0, 9'h055, 9'h055, 1, 1, 0};  // single write
        vecs[2]  = '{0, 1, 0, 0, 9'h000, 9'h000, 0, 0, 0};  // pop back to empty
        vecs[3]  = '{0, 1, 0, 0, 9'h000, 9'h000, 0, 0, 0};  // pop while empty ignored
        vecs[4]  = '{1, 1, 0, 0, 9'h033, 9'h033, 1, 1, 0};  // write+read while empty
        vecs[5]  = '{1, 0, 0, 0, 9'h1FF, 9'h033, 1, 2, 1};  // errored word sets RxErr
        vecs[6]  = '{0, 0, 0, 1, 9'h000, 9'h033, 1, 2, 0};  // Clr_Sts clears it
        vecs[7]  = '{1, 0, 0, 1, 9'h100, 9'h033, 1, 3, 1};  // set beats Clr_Sts
        vecs[8]  = '{0, 0, 0, 1, 9'h000, 9'h033, 1, 3, 0};
        vecs[9]  = '{0, 1, 0, 0, 9'h000, 9'h1FF, 1, 2, 0};
        vecs[10] = '{0, 1, 0, 0, 9'h000, 9'h100, 1, 1, 0};
        vecs[11] = '{0, 1, 0, 0, 9'h000, 9'h000, 0, 0, 0};

        Rst_N = 1'b0;
        #1;
        chk_state("reset", 9'h000, 0, 0, 0, 0, 0);
        chk("reset.to", 32'(RxTO), 0);
        @(negedge Clk); @(negedge Clk);
        Rst_N = 1'b1;
        @(negedge Clk);

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].we, vecs[i].re, vecs[i].d, vecs[i].clr, vecs[i].clrSts);
            chk_state($sformatf("vec%0d", i), vecs[i].eRhr, vecs[i].eRdy,
                      vecs[i].eCnt, 1'b0, 1'b0, vecs[i].eErr);
        end

        // fill to 16, then an overrunning 17th write that must be dropped
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 9'(i), 0, 0);
            exp_q.push_back(9'(i));
        end
        chk_state("fill16", 9'h000, 1, 16, 1, 0, 0);
        step(1, 0, 9'h0AA, 0, 0);
        chk_state("ovr", 9'h000, 1, 16, 1, 1, 0);
        step(0, 0, 9'h000, 0, 1);
        chk("ovr.clrsts", 32'(RxOvr), 0);

        // simultaneous write and read while full: pointers wrap, no overrun
        step(1, 1, 9'h077, 0, 0);
        void'(exp_q.pop_front());
        exp_q.push_back(9'h077);
        chk_state("wrfull", 9'h001, 1, 16, 1, 0, 0);

        for (int i = 0; i < 16; i++) begin
            logic [8:0] e;
            e = exp_q.pop_front();
            chk($sformatf("drain%0d", i), 32'(RHR), 32'(e));
            step(0, 1, 9'h000, 0, 0);
        end
        chk_state("drained", 9'h000, 0, 0, 0, 0, 0);

        // Clr with five words stored and a competing write
        for (int i = 0; i < 5; i++) step(1, 0, 9'(8'h10 + i), 0, 0);
        chk("clr.pre", 32'(RxCnt), 5);
        step(1, 0, 9'h1EE, 1, 0);
        chk_state("clr", 9'h000, 0, 0, 0, 0, 0);

`ifdef UART_RX_TIMEOUT_EN
        step(1, 0, 9'h042, 0, 0);
        CE_16x = 1'b1;
        for (int i = 0; i < 639; i++) @(negedge Clk);
        chk("to.639", 32'(RxTO), 0);
        @(negedge Clk);
        CE_16x = 1'b0;
        chk("to.640", 32'(RxTO), 1);
        step(0, 1, 9'h000, 0, 0);
        chk("to.pop", 32'(RxTO), 0);
`else
        step(1, 0, 9'h042, 0, 0);
        CE_16x = 1'b1;
        for (int i = 0; i < 700; i++) @(negedge Clk);
        CE_16x = 1'b0;
        chk("to.off", 32'(RxTO), 0);
        step(0, 1, 9'h000, 0, 0);
`endif

        // asynchronous reset mid-stream with three words stored
        for (int i = 0; i < 3; i++) step(1, 0, 9'(8'h21 + i), 0, 0);
        chk("arst.pre", 32'(RxCnt), 3);
        #2;
        Rst_N = 1'b0;
        #1;
        chk_state("arst", 9'h000, 0, 0, 0, 0, 0);
        chk("arst.to", 32'(RxTO), 0);
        @(negedge Clk);
        Rst_N = 1'b1;
        step(1, 0, 9'h066, 0, 0);
        chk_state("post", 9'h066, 1, 1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1);
    end

endmodule
